video_timing_gen: RTL and testbench

//  Runtime-programmable successor to the fixed MCD212 timing generator. Produces the x/y raster counters,

---
 rtl/video_timing_pkg.sv | 36 +++
 rtl/video_pixel_strobe.sv | 45 ++++
 rtl/video_timing_gen.sv | 168 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types for the programmable raster timing generator: timing set, reset set, load check.
package video_timing_pkg;
  localparam int VTG_XW = 13;
  localparam int VTG_YW = 10;
  localparam int VTG_DW = 3;

  typedef struct packed {
    logic [VTG_XW-1:0] h_total;
    logic [VTG_XW-1:0] h_start;
    logic [VTG_XW-1:0] h_active;
    logic [VTG_XW-1:0] h_sync;
    logic [VTG_YW-1:0] v_total;
    logic [VTG_YW-1:0] v_start;
    logic [VTG_YW-1:0] v_active;
    logic [VTG_YW-1:0] v_sync;
    logic              interlace;
    logic [VTG_DW-1:0] pix_div;
  } timing_cfg_t;

  localparam timing_cfg_t CFG_RESET = '{
    h_total:  VTG_XW'(120), h_start:  VTG_XW'(20), h_active: VTG_XW'(96), h_sync: VTG_XW'(9),
    v_total:  VTG_YW'(262), v_start:  VTG_YW'(18), v_active: VTG_YW'(240), v_sync: VTG_YW'(3),
    interlace: 1'b0, pix_div: VTG_DW'(1)
  };

  // Sums are one bit wider so max-size fields cannot wrap and pass the check.
  function automatic logic cfg_valid(input timing_cfg_t c);
    logic [VTG_XW:0] h_end;
    logic [VTG_YW:0] v_end;
    h_end = {1'b0, c.h_start} + {1'b0, c.h_active};
    v_end = {1'b0, c.v_start} + {1'b0, c.v_active};
    return (c.h_total >= VTG_XW'(2)) && (c.v_total >= VTG_YW'(2)) &&
           (h_end <= {1'b0, c.h_total}) && (v_end <= {1'b0, c.v_total}) &&
           (c.h_sync < c.h_total);
  endfunction
endpackage

// File: rtl/video_pixel_strobe.sv
// Pixel clock divider: restarts at the active start column, emits new_pixel and the pixel index.
module video_pixel_strobe
  import video_timing_pkg::*;
#(
  parameter int XW = VTG_XW,
  parameter int DW = VTG_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] next_x,
  input  logic [XW-1:0] h_start,
  input  logic [DW-1:0] pix_div,
  input  logic          active_next,
  output logic          new_pixel,
  output logic [XW-1:0] pixel_x
);
  logic [DW-1:0] div_q, div_d;
  logic          np_q;
  logic [XW-1:0] px_q;
  logic          line_start;

  assign line_start = (next_x == h_start);

  // >= rather than == so a divider left above a freshly applied smaller pix_div still wraps.
  always_comb begin
    div_d = div_q + 1'b1;
    if (line_start || div_q >= pix_div) div_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      np_q  <= 1'b0;
      px_q  <= '0;
    end else begin
      div_q <= div_d;
      np_q  <= active_next && (div_d == pix_div);
      if (line_start) px_q <= '0;
      else if (np_q)  px_q <= px_q + 1'b1;
    end
  end

  assign new_pixel = np_q;
  assign pixel_x   = px_q;
endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator with double-buffered timing set applied at frame start.
// Optional line-compare strobe enabled by defining VTG_LINE_IRQ_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int XW = VTG_XW,
  parameter int YW = VTG_YW,
  parameter int DW = VTG_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_load,
  input  logic [XW-1:0] cfg_h_total,
  input  logic [XW-1:0] cfg_h_start,
  input  logic [XW-1:0] cfg_h_active,
  input  logic [XW-1:0] cfg_h_sync,
  input  logic [YW-1:0] cfg_v_total,
  input  logic [YW-1:0] cfg_v_start,
  input  logic [YW-1:0] cfg_v_active,
  input  logic [YW-1:0] cfg_v_sync,
  input  logic          cfg_interlace,
  input  logic [DW-1:0] cfg_pix_div,
  input  logic [YW-1:0] cfg_irq_line,
  output logic          cfg_pending,
  output logic          cfg_err,
  output logic [XW-1:0] video_x,
  output logic [YW-1:0] video_y,
  output logic          parity,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          new_line,
  output logic          new_frame,
  output logic          new_pixel,
  output logic [XW-1:0] pixel_x,
  output logic          line_irq
);
  timing_cfg_t   act_q, shadow_q, cfg_in, nact;
  logic          pending_q, err_q, par_q, npar, apply, cfg_ok;
  logic [XW-1:0] x_q, nx, h_half;
  logic [YW-1:0] y_q, ny;
  logic [YW:0]   flen, v_end;
  logic [XW:0]   h_end;
  logic          hs_q, vs_q, hb_q, vb_q, nl_q, nf_q;
  logic          nhs, nvs, nhb, nvb, vs_after, vs_before;

  always_comb begin
    cfg_in.h_total   = cfg_h_total;
    cfg_in.h_start   = cfg_h_start;
    cfg_in.h_active  = cfg_h_active;
    cfg_in.h_sync    = cfg_h_sync;
    cfg_in.v_total   = cfg_v_total;
    cfg_in.v_start   = cfg_v_start;
    cfg_in.v_active  = cfg_v_active;
    cfg_in.v_sync    = cfg_v_sync;
    cfg_in.interlace = cfg_interlace;
    cfg_in.pix_div   = cfg_pix_div;
  end

  assign cfg_ok = cfg_valid(cfg_in);

  // Even interlaced field carries the extra line; a pending set only lands on an odd/progressive field.
  always_comb begin
    nx    = x_q + 1'b1;
    ny    = y_q;
    npar  = par_q;
    apply = 1'b0;
    nact  = act_q;
    flen  = {1'b0, act_q.v_total} + {{YW{1'b0}}, act_q.interlace & ~par_q};
    if ({1'b0, x_q} == {1'b0, act_q.h_total} - 1'b1) begin
      nx = '0;
      if ({1'b0, y_q} == flen - 1'b1) begin
        ny    = '0;
        apply = pending_q & (~act_q.interlace | ~par_q);
        npar  = apply | (act_q.interlace ? ~par_q : 1'b1);
        if (apply) nact = shadow_q;
      end else begin
        ny = y_q + 1'b1;
      end
    end
  end

  // Decode from next position and next set so the registered outputs line up with video_x/y.
  always_comb begin
    h_end     = {1'b0, nact.h_start} + {1'b0, nact.h_active};
    v_end     = {1'b0, nact.v_start} + {1'b0, nact.v_active};
    h_half    = nact.h_total >> 1;
    nhs       = nx < nact.h_sync;
    nhb       = !((nx >= nact.h_start) && ({1'b0, nx} < h_end));
    nvb       = !((ny >= nact.v_start) && ({1'b0, ny} < v_end));
    vs_after  = (ny != '0) || (nx >= h_half);
    vs_before = (ny < nact.v_sync) || ((ny == nact.v_sync) && (nx < h_half));
    nvs       = (nact.interlace && !npar) ? (vs_after && vs_before) : (ny < nact.v_sync);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      par_q     <= 1'b1;
      act_q     <= CFG_RESET;
      shadow_q  <= CFG_RESET;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hb_q      <= 1'b1;
      vb_q      <= 1'b1;
      nl_q      <= 1'b0;
      nf_q      <= 1'b0;
    end else begin
      x_q   <= nx;
      y_q   <= ny;
      par_q <= npar;
      act_q <= nact;
      if (apply) pending_q <= 1'b0;
      // A load on the apply edge lands after the old shadow was consumed.
      if (cfg_load && cfg_ok) begin
        shadow_q  <= cfg_in;
        pending_q <= 1'b1;
      end
      err_q <= cfg_load & ~cfg_ok;
      hs_q  <= nhs;
      vs_q  <= nvs;
      hb_q  <= nhb;
      vb_q  <= nvb;
      nl_q  <= (nx == '0);
      nf_q  <= (nx == '0) && (ny == '0);
    end
  end

  video_pixel_strobe #(.XW(XW), .DW(DW)) u_pix (
    .clk         (clk),
    .reset       (reset),
    .next_x      (nx),
    .h_start     (nact.h_start),
    .pix_div     (nact.pix_div),
    .active_next (~nhb & ~nvb),
    .new_pixel   (new_pixel),
    .pixel_x     (pixel_x)
  );

`ifdef VTG_LINE_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= (nx == '0) && (ny == cfg_irq_line);
  end
  assign line_irq = irq_q;
`else
  logic unused_irq_line;
  assign unused_irq_line = ^cfg_irq_line;
  assign line_irq        = 1'b0;
`endif

  assign cfg_pending = pending_q;
  assign cfg_err     = err_q;
  assign video_x     = x_q;
  assign video_y     = y_q;
  assign parity      = par_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign hblank      = hb_q;
  assign vblank      = vb_q;
  assign new_line    = nl_q;
  assign new_frame   = nf_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a formula-based reference pushes expected outputs per cycle.
module tb_video_timing_gen;
  localparam int XW = 13;
  localparam int YW = 10;
  localparam int DW = 3;
`ifdef VTG_LINE_IRQ_EN
  localparam int IRQ_EXP = 1;
`else
  localparam int IRQ_EXP = 0;
`endif

  typedef struct { int ht, hs, ha, hy, vt, vs, va, vy, il, pd; } tcfg_t;
  typedef struct { int x, y, par, hs, vs, hb, vb, nl, nf, np, px, pend, err, irq; } exp_t;

  logic clk = 1'b0, reset = 1'b1, cfg_load = 1'b0;
  logic [XW-1:0] cfg_h_total, cfg_h_start, cfg_h_active, cfg_h_sync;
  logic [YW-1:0] cfg_v_total, cfg_v_start, cfg_v_active, cfg_v_sync, cfg_irq_line;
  logic          cfg_interlace;
  logic [DW-1:0] cfg_pix_div;
  logic cfg_pending, cfg_err, parity, hsync, vsync, hblank, vblank;
  logic new_line, new_frame, new_pixel, line_irq;
  logic [XW-1:0] video_x, pixel_x;
  logic [YW-1:0] video_y;

  video_timing_gen dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .cfg_h_total(cfg_h_total), .cfg_h_start(cfg_h_start), .cfg_h_active(cfg_h_active),
    .cfg_h_sync(cfg_h_sync), .cfg_v_total(cfg_v_total), .cfg_v_start(cfg_v_start),
    .cfg_v_active(cfg_v_active), .cfg_v_sync(cfg_v_sync), .cfg_interlace(cfg_interlace),
    .cfg_pix_div(cfg_pix_div), .cfg_irq_line(cfg_irq_line),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .video_x(video_x), .video_y(video_y),
    .parity(parity), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .new_line(new_line), .new_frame(new_frame), .new_pixel(new_pixel),
    .pixel_x(pixel_x), .line_irq(line_irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  exp_t sb[$];
  tcfg_t drv, m_act, m_sh;
  int m_x, m_y, m_par, m_pend, irq_line_v;
  int f_clks, f_np, f_irq, f_par, f_rx, f_ry, f_fx, f_fy;
  logic [31:0] f_mask;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pk(int x, int y, int par, int hs, int vs, int hb, int vb,
                                     int nl, int nf, int np, int pend, int err, int irq);
    return {30'b0, XW'(x), YW'(y), par[0], hs[0], vs[0], hb[0], vb[0], nl[0], nf[0], np[0],
            pend[0], err[0], irq[0]};
  endfunction

  function automatic int cfg_ok(tcfg_t c);
    return int'(c.ht >= 2 && c.vt >= 2 && c.hs + c.ha <= c.ht && c.vs + c.va <= c.vt && c.hy < c.ht);
  endfunction

  task automatic drive_cfg(input tcfg_t c);
    drv = c;
    cfg_h_total = XW'(c.ht); cfg_h_start = XW'(c.hs); cfg_h_active = XW'(c.ha); cfg_h_sync = XW'(c.hy);
    cfg_v_total = YW'(c.vt); cfg_v_start = YW'(c.vs); cfg_v_active = YW'(c.va); cfg_v_sync = YW'(c.vy);
    cfg_interlace = c.il[0]; cfg_pix_div = DW'(c.pd);
  endtask

  task automatic set_irq(input int l);
    irq_line_v = l;
    cfg_irq_line = YW'(l);
  endtask

  // Reference: advance one clock, then derive every output straight from the raster position.
  task automatic model_step(output exp_t e);
    int flen, ap, half, pos;
    flen = m_act.vt + ((m_act.il != 0 && m_par == 0) ? 1 : 0);
    if (m_x == m_act.ht - 1) begin
      m_x = 0;
      if (m_y == flen - 1) begin
        m_y = 0;
        ap = int'(m_pend != 0 && (m_act.il == 0 || m_par == 0));
        m_par = (ap != 0) ? 1 : ((m_act.il != 0) ? 1 - m_par : 1);
        if (ap != 0) begin m_act = m_sh; m_pend = 0; end
      end else m_y++;
    end else m_x++;
    e.err = 0;
    if (cfg_load) begin
      if (cfg_ok(drv) != 0) begin m_sh = drv; m_pend = 1; end
      else e.err = 1;
    end
    e.x = m_x; e.y = m_y; e.par = m_par; e.pend = m_pend;
    e.hs = int'(m_x < m_act.hy);
    e.hb = int'(!(m_x >= m_act.hs && m_x < m_act.hs + m_act.ha));
    e.vb = int'(!(m_y >= m_act.vs && m_y < m_act.vs + m_act.va));
    half = m_act.ht / 2;
    pos  = m_y * m_act.ht + m_x;
    if (m_act.il != 0 && m_par == 0) e.vs = int'(pos >= half && pos < m_act.vy * m_act.ht + half);
    else                             e.vs = int'(m_y < m_act.vy);
    e.nl = int'(m_x == 0);
    e.nf = int'(m_x == 0 && m_y == 0);
    e.np = int'(e.hb == 0 && e.vb == 0 && ((m_x - m_act.hs) % (m_act.pd + 1)) == m_act.pd);
    e.px = (m_x - m_act.hs) / (m_act.pd + 1);
    e.irq = int'(IRQ_EXP != 0 && m_x == 0 && m_y == irq_line_v);
  endtask

  task automatic tick();
    exp_t e;
    model_step(e);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("outs", pk(video_x, video_y, parity, hsync, vsync, hblank, vblank, new_line, new_frame,
                   new_pixel, cfg_pending, cfg_err, line_irq),
        pk(e.x, e.y, e.par, e.hs, e.vs, e.hb, e.vb, e.nl, e.nf, e.np, e.pend, e.err, e.irq));
    if (e.np != 0) chk("pixel_x", 64'(pixel_x), 64'(e.px));
  endtask

  task automatic load(input tcfg_t c);
    drive_cfg(c);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic wait_apply(input int max);
    int n = 0;
    while (cfg_pending && n < max) begin tick(); n++; end
    chk("apply_nf", 64'(new_frame), 64'(1));
    chk("apply_pend", 64'(cfg_pending), 64'(0));
  endtask

  task automatic wait_frame(input int max);
    int n = 0;
    do begin tick(); n++; end while (!new_frame && n < max);
    chk("frame_seen", 64'(new_frame), 64'(1));
  endtask

  // Starts on a new_frame cycle; ends on the next one, counting the cycles in between.
  task automatic run_field();
    logic pv;
    f_clks = 0; f_np = 0; f_irq = 0; f_mask = '0;
    f_rx = -1; f_ry = -1; f_fx = -1; f_fy = -1;
    pv = vsync;
    do begin
      tick();
      f_clks++;
      if (f_clks == 1) f_par = int'(parity);
      if (!new_frame) begin
        if (new_pixel) begin
          f_np++;
          if (video_x < 32) f_mask[video_x[4:0]] = 1'b1;
        end
        if (line_irq) f_irq++;
        if (vsync && !pv) begin f_rx = int'(video_x); f_ry = int'(video_y); end
        if (!vsync && pv) begin f_fx = int'(video_x); f_fy = int'(video_y); end
      end
      pv = vsync;
    end while (!new_frame && f_clks < 2000);
    chk("field_end", 64'(new_frame), 64'(1));
  endtask

  initial begin
    tcfg_t a, ai, b1, b2, bad, d;
    int n;
    a   = '{ht: 20, hs: 4, ha: 10, hy: 3, vt: 8, vs: 2, va: 4, vy: 2, il: 0, pd: 0};
    ai  = a;  ai.il = 1;
    b1  = a;  b1.pd = 1;
    b2  = a;  b2.pd = 2;
    bad = a;  bad.hs = 15;
    d   = a;  d.ht = 24;
    drive_cfg(a);
    set_irq(5);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 64'(video_x), 64'(0));
    chk("rst_y", 64'(video_y), 64'(0));
    chk("rst_sync_blank_par", {60'b0, hsync, vsync, hblank, vblank} | {63'b0, parity} << 4, 64'h1F);
    chk("rst_strobes", {60'b0, new_line, new_frame, new_pixel, line_irq}, 64'(0));
    chk("rst_cfg", {62'b0, cfg_pending, cfg_err}, 64'(0));
    chk("rst_pixel_x", 64'(pixel_x), 64'(0));
    m_x = 0; m_y = 0; m_par = 1; m_pend = 0;
    m_act = '{ht: 120, hs: 20, ha: 96, hy: 9, vt: 262, vs: 18, va: 240, vy: 3, il: 0, pd: 1};
    m_sh = m_act;
    reset = 1'b0;

    load(a);
    chk("pend_set", 64'(cfg_pending), 64'(1));
    wait_apply(40000);
    run_field();
    chk("ni_clk", 64'(f_clks), 64'(160));
    chk("ni_np", 64'(f_np), 64'(40));
    chk("ni_par", 64'(f_par), 64'(1));
    chk("ni_irq", 64'(f_irq), 64'(IRQ_EXP));

    load(bad);
    chk("rej_err", 64'(cfg_err), 64'(1));
    chk("rej_pend", 64'(cfg_pending), 64'(0));
    tick();
    chk("err_pulse", 64'(cfg_err), 64'(0));
    wait_frame(400);
    run_field();
    chk("rej_clk", 64'(f_clks), 64'(160));

    load(ai);
    wait_apply(400);
    run_field();
    chk("il_odd_clk", 64'(f_clks), 64'(160));
    chk("il_odd_par", 64'(f_par), 64'(1));
    run_field();
    chk("il_even_clk", 64'(f_clks), 64'(180));
    chk("il_even_par", 64'(f_par), 64'(0));
    chk("vs_rise", {32'(f_rx), 32'(f_ry)}, {32'd10, 32'd0});
    chk("vs_fall", {32'(f_fx), 32'(f_fy)}, {32'd10, 32'd2});

    repeat (5) tick();
    load(b1);
    repeat (5) tick();
    load(b2);
    chk("dbl_pend", 64'(cfg_pending), 64'(1));
    wait_apply(1000);
    run_field();
    chk("div_clk", 64'(f_clks), 64'(160));
    chk("div_np", 64'(f_np), 64'(12));
    chk("div_mask", 64'(f_mask), 64'h1240);
    chk("div_irq", 64'(f_irq), 64'(IRQ_EXP));

    set_irq(9);
    run_field();
    chk("irq_none", 64'(f_irq), 64'(0));

    load(a);
    n = 0;
    while (!(m_x == m_act.ht - 1 && m_y == m_act.vt - 1) && n < 500) begin tick(); n++; end
    load(d);
    chk("co_nf", 64'(new_frame), 64'(1));
    chk("co_pend", 64'(cfg_pending), 64'(1));
    run_field();
    chk("co_clk", 64'(f_clks), 64'(160));
    chk("co_np", 64'(f_np), 64'(40));
    chk("co_pend_clr", 64'(cfg_pending), 64'(0));
    run_field();
    chk("co_d_clk", 64'(f_clks), 64'(192));

    repeat (7) tick();
    reset = 1'b1;
    #1;
    chk("async_x", 64'(video_x), 64'(0));
    chk("async_hb", 64'(hblank), 64'(1));
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
